// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO with fill level, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_fwft #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 8,
    parameter int AF_THRESH = 2**AWIDTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              clear_err,
    input  logic              write_en,
    input  logic [DWIDTH-1:0] write_data,
    output logic              full,
    output logic              almost_full,
    input  logic              read_en,
    output logic [DWIDTH-1:0] read_data,
    output logic              empty,
    output logic              almost_empty,
    output logic [AWIDTH:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 2**AWIDTH;
    localparam logic [AWIDTH:0] AF_LVL  = AF_THRESH[AWIDTH:0];
    localparam logic [AWIDTH:0] AE_LVL  = AE_THRESH[AWIDTH:0];
    localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AWIDTH:0]   r_wr_ptr;
    logic [AWIDTH:0]   r_rd_ptr;
    logic [AWIDTH:0]   r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_overflow;
    logic              r_underflow;
    logic [DWIDTH-1:0] r_rd_data;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    logic [AWIDTH:0]   w_wr_ptr_nxt;
    logic [AWIDTH:0]   w_rd_ptr_nxt;
    logic [AWIDTH:0]   w_level_nxt;
    logic              w_empty_nxt;
    logic              w_full_nxt;
    logic [DWIDTH-1:0] w_head_nxt;
    logic [DWIDTH-1:0] w_rd_data_nxt;

    // A read frees a slot this edge, so a write is accepted even when full.
    assign w_wr_acc  = write_en && (!r_full || read_en);
    assign w_rd_acc  = read_en && !r_empty;
    assign w_ovf_evt = write_en && r_full && !read_en;
    assign w_udf_evt = read_en && r_empty;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
        if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
        if (w_wr_acc && !w_rd_acc) w_level_nxt = r_level + PTR_ONE;
        if (!w_wr_acc && w_rd_acc) w_level_nxt = r_level - PTR_ONE;

        w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_full_nxt  = (w_wr_ptr_nxt[AWIDTH] != w_rd_ptr_nxt[AWIDTH]) &&
                      (w_wr_ptr_nxt[AWIDTH-1:0] == w_rd_ptr_nxt[AWIDTH-1:0]);

        // The next head may be the word landing this very edge; bypass the array.
        if (w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = write_data;
        else                                        w_head_nxt = r_mem[w_rd_ptr_nxt[AWIDTH-1:0]];

        w_rd_data_nxt = w_empty_nxt ? r_rd_data : w_head_nxt;
    end

    // NOTE: the storage array has no reset; stale words are unreachable because the pointers are reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr_acc) r_mem[r_wr_ptr[AWIDTH-1:0]] <= write_data;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_rd_data      <= '0;
        end else if (flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= ('0 >= AF_LVL);
            r_almost_empty <= ('0 <= AE_LVL);
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_level        <= w_level_nxt;
            r_full         <= w_full_nxt;
            r_empty        <= w_empty_nxt;
            r_almost_full  <= (w_level_nxt >= AF_LVL);
            r_almost_empty <= (w_level_nxt <= AE_LVL);
            r_overflow     <= w_ovf_evt || (r_overflow && !clear_err);
            r_underflow    <= w_udf_evt || (r_underflow && !clear_err);
            r_rd_data      <= w_rd_data_nxt;
        end
    end

    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign read_data    = r_rd_data;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed self-checking bench for sync_fifo_fwft (DWIDTH=16, AWIDTH=8).
module tb_sync_fifo_fwft;

    logic        clk = 1'b0;
    logic        rst, flush, clear_err, write_en, read_en;
    logic [15:0] write_data;
    logic        full, almost_full, empty, almost_empty, overflow, underflow;
    logic [15:0] read_data;
    logic [8:0]  level;
    int          n_cmp = 0;
    int          n_mis = 0;

    sync_fifo_fwft #(.DWIDTH(16), .AWIDTH(8), .AF_THRESH(252), .AE_THRESH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .clear_err(clear_err),
        .write_en(write_en), .write_data(write_data),
        .full(full), .almost_full(almost_full),
        .read_en(read_en), .read_data(read_data),
        .empty(empty), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; clear_err = 1'b0;
        write_en = 1'b0; read_en = 1'b0; write_data = '0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        n_cmp++; if (empty !== 1'b1)        begin n_mis++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_mis++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
        n_cmp++; if (full !== 1'b0)         begin n_mis++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (almost_full !== 1'b0)  begin n_mis++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
        n_cmp++; if (level !== 9'd0)        begin n_mis++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (read_data !== 16'h0)   begin n_mis++; $display("FAIL reset_read_data: got %h want 0000", read_data); end
        n_cmp++; if (overflow !== 1'b0)     begin n_mis++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (underflow !== 1'b0)    begin n_mis++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    endtask

    task automatic test_basic();
        logic [15:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        write_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_data = vals[i];
            tick();
            if (i == 0) begin
                n_cmp++; if (empty !== 1'b0)        begin n_mis++; $display("FAIL basic_first_empty: got %b want 0", empty); end
                n_cmp++; if (read_data !== 16'h1111) begin n_mis++; $display("FAIL basic_first_head: got %h want 1111", read_data); end
            end
        end
        write_en = 1'b0;
        n_cmp++; if (level !== 9'd3) begin n_mis++; $display("FAIL basic_level3: got %0d want 3", level); end
        read_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (read_data !== vals[i]) begin n_mis++; $display("FAIL basic_pop%0d: got %h want %h", i, read_data, vals[i]); end
            tick();
        end
        read_en = 1'b0;
        n_cmp++; if (empty !== 1'b1)         begin n_mis++; $display("FAIL basic_drained_empty: got %b want 1", empty); end
        n_cmp++; if (level !== 9'd0)         begin n_mis++; $display("FAIL basic_drained_level: got %0d want 0", level); end
        n_cmp++; if (read_data !== 16'h3333) begin n_mis++; $display("FAIL basic_hold_last: got %h want 3333", read_data); end
    endtask

    task automatic test_back_to_back();
        write_en = 1'b1; write_data = 16'h5000;
        tick();
        read_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            write_data = 16'h5000 | 16'(k);
            tick();
            n_cmp++; if (read_data !== (16'h5000 | 16'(k))) begin n_mis++; $display("FAIL b2b_head%0d: got %h want %h", k, read_data, 16'h5000 | 16'(k)); end
            n_cmp++; if (level !== 9'd1) begin n_mis++; $display("FAIL b2b_level%0d: got %0d want 1", k, level); end
        end
        write_en = 1'b0;
        tick();
        read_en = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_mis++; $display("FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_fill_passthrough_drain();
        logic [15:0] exp;
        write_en = 1'b1;
        for (int i = 0; i < 260; i++) begin
            write_data = i[15:0];
            tick();
            if (i == 3)   begin n_cmp++; if (almost_empty !== 1'b1) begin n_mis++; $display("FAIL fill_ae_at4: got %b want 1", almost_empty); end end
            if (i == 4)   begin n_cmp++; if (almost_empty !== 1'b0) begin n_mis++; $display("FAIL fill_ae_at5: got %b want 0", almost_empty); end end
            if (i == 250) begin n_cmp++; if (almost_full !== 1'b0)  begin n_mis++; $display("FAIL fill_af_at251: got %b want 0", almost_full); end end
            if (i == 251) begin n_cmp++; if (almost_full !== 1'b1)  begin n_mis++; $display("FAIL fill_af_at252: got %b want 1", almost_full); end end
            if (i == 254) begin n_cmp++; if (full !== 1'b0)         begin n_mis++; $display("FAIL fill_full_at255: got %b want 0", full); end end
            if (i == 255) begin
                n_cmp++; if (full !== 1'b1)     begin n_mis++; $display("FAIL fill_full_at256: got %b want 1", full); end
                n_cmp++; if (level !== 9'd256)  begin n_mis++; $display("FAIL fill_level256: got %0d want 256", level); end
                n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL fill_no_ovf_yet: got %b want 0", overflow); end
            end
            if (i == 256) begin n_cmp++; if (overflow !== 1'b1) begin n_mis++; $display("FAIL fill_ovf_set: got %b want 1", overflow); end end
        end
        write_en = 1'b0;
        n_cmp++; if (level !== 9'd256) begin n_mis++; $display("FAIL fill_level_after_drop: got %0d want 256", level); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL clear_ovf: got %b want 0", overflow); end

        write_en = 1'b1; read_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            write_data = 16'hA000 | 16'(k);
            n_cmp++; if (read_data !== 16'(k)) begin n_mis++; $display("FAIL pass_head%0d: got %h want %h", k, read_data, 16'(k)); end
            tick();
            n_cmp++; if (level !== 9'd256 || full !== 1'b1) begin n_mis++; $display("FAIL pass_full%0d: got level %0d full %b want 256/1", k, level, full); end
        end
        write_en = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL pass_no_ovf: got %b want 0", overflow); end

        for (int j = 0; j < 256; j++) begin
            exp = (j < 246) ? 16'(j + 10) : (16'hA000 | 16'(j - 246));
            n_cmp++; if (read_data !== exp) begin n_mis++; $display("FAIL drain%0d: got %h want %h", j, read_data, exp); end
            tick();
        end
        read_en = 1'b0;
        n_cmp++; if (empty !== 1'b1 || level !== 9'd0) begin n_mis++; $display("FAIL drain_end: got empty %b level %0d want 1/0", empty, level); end
    endtask

    task automatic test_underflow();
        read_en = 1'b1; write_en = 1'b1; write_data = 16'hABCD;
        tick();
        read_en = 1'b0; write_en = 1'b0;
        n_cmp++; if (underflow !== 1'b1)     begin n_mis++; $display("FAIL udf_set: got %b want 1", underflow); end
        n_cmp++; if (level !== 9'd1)         begin n_mis++; $display("FAIL udf_level: got %0d want 1", level); end
        n_cmp++; if (read_data !== 16'hABCD) begin n_mis++; $display("FAIL udf_head: got %h want abcd", read_data); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_cmp++; if (underflow !== 1'b0) begin n_mis++; $display("FAIL udf_clear: got %b want 0", underflow); end
        read_en = 1'b1;
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0; read_en = 1'b0;
        n_cmp++; if (underflow !== 1'b1) begin n_mis++; $display("FAIL udf_clear_vs_event: got %b want 1", underflow); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    task automatic test_flush_and_reset();
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        write_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            write_data = 16'h7000 | 16'(i);
            tick();
        end
        n_cmp++; if (level !== 9'd100) begin n_mis++; $display("FAIL flush_prefill: got %0d want 100", level); end
        flush = 1'b1; write_data = 16'hDEAD;
        tick();
        flush = 1'b0; write_en = 1'b0;
        n_cmp++; if (level !== 9'd0 || empty !== 1'b1 || full !== 1'b0) begin n_mis++; $display("FAIL flush_state: got level %0d empty %b full %b want 0/1/0", level, empty, full); end
        n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_mis++; $display("FAIL flush_almost: got ae %b af %b want 1/0", almost_empty, almost_full); end
        n_cmp++; if (underflow !== 1'b1 || overflow !== 1'b0) begin n_mis++; $display("FAIL flush_sticky: got udf %b ovf %b want 1/0", underflow, overflow); end
        tick();
        n_cmp++; if (level !== 9'd0) begin n_mis++; $display("FAIL flush_write_ignored: got %0d want 0", level); end

        write_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            write_data = 16'h9000 | 16'(i);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; write_en = 1'b0;
        n_cmp++; if (level !== 9'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin n_mis++; $display("FAIL rst_level: got level %0d empty %b ae %b want 0/1/1", level, empty, almost_empty); end
        n_cmp++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_mis++; $display("FAIL rst_full: got full %b af %b want 0/0", full, almost_full); end
        n_cmp++; if (read_data !== 16'h0) begin n_mis++; $display("FAIL rst_read_data: got %h want 0000", read_data); end
        n_cmp++; if (underflow !== 1'b0 || overflow !== 1'b0) begin n_mis++; $display("FAIL rst_sticky: got udf %b ovf %b want 0/0", underflow, overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_fill_passthrough_drain();
        test_underflow();
        test_flush_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Single-clock, show-ahead (first-word-fall-through) FIFO: the parametrised successor to the team's dual-clock FIFO, for paths where producer and consumer share one clock. It adds a fill-level output, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between the sample capture logic and downstream consumers in the FPGA datapath.

## Interface
- DWIDTH, 16, data word width in bits
- AWIDTH, 8, address width; depth = 2**AWIDTH words (exact usable capacity)
- AF_THRESH, 2**AWIDTH-4, almost_full asserted when level >= AF_THRESH
- AE_THRESH, 4, almost_empty asserted when level <= AE_THRESH

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all stored words
- clear_err  in  1  clear sticky overflow/underflow
- write_en  in  1  push write_data
- write_data  in  DWIDTH  word to push
- full  out  1  level == 2**AWIDTH
- almost_full  out  1  level >= AF_THRESH
- read_en  in  1  pop head word
- read_data  out  DWIDTH  current head word (show-ahead)
- empty  out  1  level == 0
- almost_empty  out  1  level <= AE_THRESH
- level  out  AWIDTH+1  words stored, 0..2**AWIDTH
- overflow  out  1  sticky: write attempted while full and not popped
- underflow  out  1  sticky: read attempted while empty

## Operation
- Priority per edge: rst > flush > read/write.
- Write accepted when write_en && (!full || read_en). Rejected write: data dropped, overflow set.
- Read accepted when read_en && !empty. read_en while empty: no pop, underflow set; a same-cycle write is still accepted.
- Simultaneous accepted read+write: level unchanged; full stays full, passthrough allowed.
- Show-ahead: while !empty, read_data equals the oldest stored word; read_en pops it and read_data shows the next word after the edge.
- While empty, read_data holds the last value it presented (0 after reset).
- Pointers are AWIDTH+1 bits, wrap modulo 2**(AWIDTH+1); full/empty derived from pointer MSB/equality and must agree with level.
- flush: pointers and level to 0, empty=1, full=0, almost flags recomputed; write_en/read_en in the flush cycle ignored, no errors raised; sticky flags untouched.
- clear_err clears overflow/underflow; an error event in the same cycle wins (flag stays 1).
- rst mid-operation: all contents discarded, every output to reset value next edge.
- Reset values: empty=1, almost_empty=1, full=0, almost_full=0, level=0, overflow=0, underflow=0, read_data=0.

## Timing
- All outputs registered; update on the rising edge sampling the causing input.
- Write-to-empty latency: 1 cycle; after the edge sampling write_en, empty=0 and read_data=written word.
- Pop latency: 1 cycle; next head on read_data after the sampling edge.
- level, full, empty, almost_* reflect all accepted operations of the previous edge; never lag each other.
- Sustained throughput: one write and one read per cycle, no bubbles, including when full or holding one word.
- Error flags set on the edge sampling the offending request.

## Test plan
- Reset, then idle 5 cycles -> empty=1, almost_empty=1, full=0, level=0, read_data=0, overflow=underflow=0.
- Write 0x1111, 0x2222, 0x3333 on consecutive cycles -> empty=0 one cycle after first write, read_data=0x1111 immediately; three pops return 0x1111, 0x2222, 0x3333, then empty=1, level=0.
- Write 260 words 0x0000..0x0103 with read_en=0 -> full=1 and level=256 after word 0x00FF, almost_full=1 from level 252, last 4 dropped, overflow=1; drain returns 0x0000..0x00FF in order.
- At full, assert write_en and read_en together for 10 cycles -> level stays 256, full stays 1, no overflow, output order preserved across pointer wrap.
- read_en on empty with write_en=1 data 0xABCD -> underflow=1, level=1, read_data=0xABCD; clear_err with no error -> underflow=0; clear_err with concurrent empty read -> underflow stays 1.
- Fill to 100 words, pulse flush with write_en=1 -> level=0, empty=1, overflow/underflow unchanged; then rst mid-burst -> all outputs at reset values next edge.
